// File: rtl/spu_mem_stage.sv
// spu_mem_stage: MEM-stage local-store access FSM; optional watchdog enabled by MEM_TIMEOUT_EN
module spu_mem_stage #(
    parameter int DATA_W    = 128,
    parameter int RT_W      = 7,
    parameter int LS_ADDR_W = 18
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic                 ex_load,
    input  logic                 ex_store,
    input  logic                 ex_regwrite,
    input  logic [DATA_W-1:0]    ex_alu_result,
    input  logic [DATA_W-1:0]    ex_store_data,
    input  logic [RT_W-1:0]      ex_rt,
    output logic                 stall,
    output logic                 ls_req,
    output logic                 ls_we,
    output logic [LS_ADDR_W-5:0] ls_addr,
    output logic [DATA_W-1:0]    ls_wdata,
    input  logic                 ls_gnt,
    input  logic                 ls_rvalid,
    input  logic [DATA_W-1:0]    ls_rdata,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [RT_W-1:0]      wb_rt,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 err_timeout
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

    state_e               state_q;
    logic [LS_ADDR_W-5:0] addr_q;
    logic                 we_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [RT_W-1:0]      rt_q;
    logic                 wb_valid_q;
    logic                 wb_we_q;
    logic [RT_W-1:0]      wb_rt_q;
    logic [DATA_W-1:0]    wb_data_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             expired;
    assign expired     = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign stall    = (state_q != IDLE);
    assign ls_req   = (state_q == REQ);
    assign ls_we    = we_q;
    assign ls_addr  = addr_q;
    assign ls_wdata = wdata_q;
    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rt    = wb_rt_q;
    assign wb_data  = wb_data_q;

    // Sequence each access through IDLE/REQ/WAIT_R; the address keeps only the quadword index of the preferred slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rt_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rt_q    <= '0;
            wb_data_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q      <= 1'b0;
            cnt_q      <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
`endif
            case (state_q)
                IDLE: if (ex_valid) begin
                    if (ex_load || ex_store) begin
                        state_q <= REQ;
                        addr_q  <= ex_alu_result[DATA_W-32+LS_ADDR_W-1:DATA_W-28];
                        we_q    <= ex_store;
                        rt_q    <= ex_rt;
                        if (ex_store) wdata_q <= ex_store_data;
                    end else begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= ex_regwrite;
                        wb_rt_q    <= ex_rt;
                        wb_data_q  <= ex_alu_result;
                    end
                end
                REQ: if (ls_gnt) state_q <= we_q ? IDLE : WAIT_R;
                WAIT_R: if (ls_rvalid) begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b1;
                    wb_we_q    <= 1'b1;
                    wb_rt_q    <= rt_q;
                    wb_data_q  <= ls_rdata;
                end
                default: state_q <= IDLE;
            endcase
`ifdef MEM_TIMEOUT_EN
            if (expired) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
                if (!we_q) begin
                    wb_valid_q <= 1'b1;
                    wb_we_q    <= 1'b0;
                    wb_data_q  <= '0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_spu_mem_stage.sv
// tb_spu_mem_stage: directed and randomized checks of spu_mem_stage against a transaction-level model
module tb_spu_mem_stage;
    localparam int DW = 128;
    localparam int RW = 7;
    localparam int AW = 18;
    localparam int QW = AW - 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid, ex_load, ex_store, ex_regwrite;
    logic [DW-1:0] ex_alu_result, ex_store_data, ls_wdata, ls_rdata, wb_data;
    logic [RW-1:0] ex_rt, wb_rt;
    logic          stall, ls_req, ls_we, ls_gnt, ls_rvalid, wb_valid, wb_we, err_timeout;
    logic [QW-1:0] ls_addr;

    int            vectors = 0;
    int            miscompares = 0;
    int            n;
    logic [DW-1:0] last_data = '0;
    logic [RW-1:0] last_rt = '0;

    always #5 clk = ~clk;

    spu_mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_regwrite(ex_regwrite),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rt(ex_rt),
        .stall(stall), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rt(wb_rt), .wb_data(wb_data),
        .err_timeout(err_timeout)
    );

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Quadword index of the preferred-slot byte address, wrapped to the local-store size
    function automatic logic [QW-1:0] qidx(input logic [DW-1:0] alu);
        logic [31:0] slot;
        slot = alu[DW-1:DW-32];
        return QW'((slot / 32'd16) % (32'd1 << QW));
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ex_valid      = 1'b0;
        ex_load       = 1'($urandom_range(0, 1));
        ex_store      = 1'($urandom_range(0, 1));
        ex_regwrite   = 1'($urandom_range(0, 1));
        ex_rt         = RW'($urandom());
        ex_alu_result = rnd128();
        ex_store_data = rnd128();
        ls_gnt        = 1'b0;
        ls_rvalid     = 1'($urandom_range(0, 1));
        ls_rdata      = rnd128();
    endtask

    task automatic do_alu(input logic [RW-1:0] rt, input logic [DW-1:0] alu, input logic rw);
        ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
        ex_regwrite = rw; ex_rt = rt; ex_alu_result = alu; ex_store_data = rnd128();
        chk("alu_stall_pre", stall, 0);
        tick();
        quiet();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_we", wb_we, rw);
        chk("alu_wb_rt", wb_rt, rt);
        chk("alu_wb_data", wb_data, alu);
        chk("alu_stall", stall, 0);
        chk("alu_ls_req", ls_req, 0);
        last_data = alu; last_rt = rt;
        tick();
        chk("alu_pulse_end", wb_valid, 0);
        chk("alu_we_end", wb_we, 0);
        chk("alu_data_hold", wb_data, last_data);
    endtask

    task automatic do_store(input logic [DW-1:0] alu, input logic [DW-1:0] data, input int gd, input logic both);
        ex_valid = 1'b1; ex_store = 1'b1; ex_load = both;
        ex_regwrite = 1'($urandom_range(0, 1)); ex_rt = RW'($urandom());
        ex_alu_result = alu; ex_store_data = data;
        tick();
        quiet();
        for (int k = 0; k <= gd; k++) begin
            chk("st_req", ls_req, 1);
            chk("st_stall", stall, 1);
            chk("st_we", ls_we, 1);
            chk("st_addr", ls_addr, qidx(alu));
            chk("st_wdata", ls_wdata, data);
            chk("st_no_wb", wb_valid, 0);
            ls_gnt = (k == gd);
            ls_rvalid = 1'($urandom_range(0, 1));
            tick();
        end
        ls_gnt = 1'b0;
        chk("st_done_req", ls_req, 0);
        chk("st_done_stall", stall, 0);
        chk("st_done_no_wb", wb_valid, 0);
        chk("st_wb_data_hold", wb_data, last_data);
        chk("st_wb_rt_hold", wb_rt, last_rt);
        chk("st_no_err", err_timeout, 0);
    endtask

    task automatic do_load(input logic [DW-1:0] alu, input logic [RW-1:0] rt, input int gd, input int rd,
                           input logic [DW-1:0] rdata, input logic hold, input logic [RW-1:0] hrt,
                           input logic [DW-1:0] halu);
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0;
        ex_regwrite = 1'($urandom_range(0, 1)); ex_rt = rt; ex_alu_result = alu; ex_store_data = rnd128();
        tick();
        quiet();
        if (hold) begin
            ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
            ex_regwrite = 1'b1; ex_rt = hrt; ex_alu_result = halu;
        end
        for (int k = 0; k <= gd; k++) begin
            chk("ld_req", ls_req, 1);
            chk("ld_stall", stall, 1);
            chk("ld_we", ls_we, 0);
            chk("ld_addr", ls_addr, qidx(alu));
            chk("ld_no_wb", wb_valid, 0);
            ls_gnt = (k == gd);
            ls_rvalid = 1'($urandom_range(0, 1));
            ls_rdata = rnd128();
            tick();
        end
        for (int k = 0; k <= rd; k++) begin
            chk("ld_wait_req", ls_req, 0);
            chk("ld_wait_stall", stall, 1);
            chk("ld_wait_no_wb", wb_valid, 0);
            ls_gnt = 1'($urandom_range(0, 1));
            ls_rvalid = (k == rd);
            ls_rdata = (k == rd) ? rdata : rnd128();
            tick();
        end
        ls_gnt = 1'b0; ls_rvalid = 1'b0;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_we", wb_we, 1);
        chk("ld_wb_rt", wb_rt, rt);
        chk("ld_wb_data", wb_data, rdata);
        chk("ld_stall_end", stall, 0);
        last_data = rdata; last_rt = rt;
        if (hold) begin
            tick();
            chk("ord_wb_valid", wb_valid, 1);
            chk("ord_wb_rt", wb_rt, hrt);
            chk("ord_wb_data", wb_data, halu);
            chk("ord_stall", stall, 0);
            last_data = halu; last_rt = hrt;
        end
        quiet();
        tick();
        chk("ld_pulse_end", wb_valid, 0);
    endtask

    task automatic arst(input logic in_wait);
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_rt = 7'd11; ex_alu_result = rnd128();
        tick();
        quiet();
        if (in_wait) begin
            ls_gnt = 1'b1;
            tick();
            ls_gnt = 1'b0;
            chk("arst_in_wait", stall, 1);
        end else begin
            chk("arst_in_req", ls_req, 1);
        end
        ls_rvalid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_req", ls_req, 0);
        chk("arst_stall", stall, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_ls_addr", ls_addr, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        last_data = '0; last_rt = '0;
        ls_rvalid = 1'b1; ls_rdata = rnd128();
        tick();
        ls_rvalid = 1'b0;
        chk("arst_no_wb", wb_valid, 0);
        chk("arst_idle", stall, 0);
        tick();
        chk("arst_no_wb2", wb_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_load = 1'($urandom_range(0, 1)); ex_store = 1'($urandom_range(0, 1));
            ls_gnt = 1'($urandom_range(0, 1)); ls_rvalid = 1'($urandom_range(0, 1));
            tick();
            chk("rst_flags", {stall, ls_req, ls_we, wb_valid, wb_we, err_timeout}, 0);
            chk("rst_ls_addr", ls_addr, 0);
            chk("rst_ls_wdata", ls_wdata, 0);
            chk("rst_wb_rt", wb_rt, 0);
            chk("rst_wb_data", wb_data, 0);
        end
        reset = 1'b1;
        quiet();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_req", ls_req, 0);
            chk("rel_stall", stall, 0);
            chk("rel_wb", wb_valid, 0);
        end

        do_alu(7'd5, 128'hA5, 1'b1);
        do_alu(7'd127, rnd128(), 1'b0);
        do_store({32'h0000_1237, 96'(rnd128())}, 128'hDEAD, 3, 1'b0);
        do_store({32'hFFFF_FFFF, 96'(rnd128())}, rnd128(), 0, 1'b1);
        do_store({32'h0004_000F, 96'(rnd128())}, rnd128(), 1, 1'b0);
        do_load({32'h0000_0040, 96'(rnd128())}, 7'd9, 0, 2, 128'hBEEF, 1'b0, 7'd0, '0);
        do_load({32'h0000_0100, 96'(rnd128())}, 7'd20, 1, 0, rnd128(), 1'b1, 7'd3, 128'h1234_5678);
        arst(1'b1);
        arst(1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: do_alu(RW'($urandom()), rnd128(), 1'($urandom_range(0, 1)));
                1: do_store(rnd128(), rnd128(), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
                default: do_load(rnd128(), RW'($urandom()), $urandom_range(0, 4), $urandom_range(0, 4),
                                 rnd128(), 1'($urandom_range(0, 1)), RW'($urandom()), rnd128());
            endcase
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                quiet();
                tick();
                chk("gap_idle", {stall, ls_req, wb_valid}, 0);
            end
        end

`ifdef MEM_TIMEOUT_EN
        ex_valid = 1'b1; ex_store = 1'b1; ex_load = 1'b0; ex_alu_result = rnd128(); ex_store_data = rnd128();
        tick();
        quiet();
        n = 0;
        for (int k = 0; k < 400 && stall; k++) begin
            n++;
            chk("to_st_no_err", err_timeout, 0);
            tick();
        end
        chk("to_st_cycles", n, 255);
        chk("to_st_err", err_timeout, 1);
        chk("to_st_no_wb", wb_valid, 0);
        chk("to_st_req", ls_req, 0);
        tick();
        chk("to_st_err_pulse", err_timeout, 0);
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_rt = 7'd44; ex_alu_result = rnd128();
        tick();
        quiet();
        n = 0;
        for (int k = 0; k < 400 && stall; k++) begin
            n++;
            tick();
        end
        chk("to_ld_cycles", n, 255);
        chk("to_ld_err", err_timeout, 1);
        chk("to_ld_wb_valid", wb_valid, 1);
        chk("to_ld_wb_we", wb_we, 0);
        chk("to_ld_wb_data", wb_data, 0);
        tick();
        chk("to_ld_err_pulse", err_timeout, 0);
        chk("to_ld_wb_pulse", wb_valid, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
